// File: rtl/data_sram_bridge.sv
// data_sram_bridge
// Turns the core's single-cycle data_sram_* access into a req/addr_ok/data_ok
// bus transaction and stalls the pipeline until that transaction completes.
// Read data stays in a buffer and is presented to the core in the release cycle.
// Optional stall-cycle counter port: define DATA_SRAM_BRIDGE_STALL_CNT_EN.
module data_sram_bridge #(
    parameter int CNT_WIDTH  = 32,
    parameter int ADDR_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  data_sram_en,
    input  logic [3:0]            data_sram_wen,
    input  logic [ADDR_WIDTH-1:0] data_sram_addr,
    input  logic [31:0]           data_sram_wdata,
    output logic [31:0]           data_sram_rdata,
    output logic                  stallreq,
    output logic                  data_req,
    output logic                  data_wr,
    output logic [1:0]            data_size,
    output logic [ADDR_WIDTH-1:0] data_addr,
    output logic [31:0]           data_wdata,
    input  logic                  data_addr_ok,
    input  logic [31:0]           data_rdata,
    input  logic                  data_data_ok
`ifdef DATA_SRAM_BRIDGE_STALL_CNT_EN
    ,
    output logic [CNT_WIDTH-1:0]  stall_cnt
`endif
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t                r_state;
    state_t                w_next;

    logic                  r_wr;
    logic [1:0]            r_size;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [31:0]           r_wdata;
    logic [31:0]           r_rdata_buf;

    logic                  w_wr;
    logic [1:0]            w_size;
    logic [1:0]            w_off;
    logic                  w_rd_capture;

    // Bus size/offset from the byte enables; reads and odd patterns go out as aligned words
    always_comb begin
        w_wr   = |data_sram_wen;
        w_size = 2'd2;
        w_off  = 2'b00;
        case (data_sram_wen)
            4'b0011: begin w_size = 2'd1; w_off = 2'b00; end
            4'b1100: begin w_size = 2'd1; w_off = 2'b10; end
            4'b0001: begin w_size = 2'd0; w_off = 2'b00; end
            4'b0010: begin w_size = 2'd0; w_off = 2'b01; end
            4'b0100: begin w_size = 2'd0; w_off = 2'b10; end
            4'b1000: begin w_size = 2'd0; w_off = 2'b11; end
            default: begin w_size = 2'd2; w_off = 2'b00; end
        endcase
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) r_state <= IDLE;
        else     r_state <= w_next;
    end

    // Next state plus the combinational stall/request outputs
    always_comb begin
        w_next   = r_state;
        stallreq = 1'b0;
        data_req = 1'b0;
        case (r_state)
            IDLE: begin
                // stall in the very cycle the core presents the access
                stallreq = data_sram_en;
                if (data_sram_en) w_next = REQ;
            end
            REQ: begin
                stallreq = 1'b1;
                data_req = 1'b1;
                if (data_addr_ok) w_next = data_data_ok ? DONE : WAIT;
            end
            WAIT: begin
                stallreq = 1'b1;
                if (data_data_ok) w_next = DONE;
            end
            DONE: begin
                // one free cycle; the access still on the port is the finished one
                w_next = IDLE;
            end
            default: w_next = IDLE;
        endcase
    end

    // Read data arrives either together with addr_ok or later in WAIT
    assign w_rd_capture = !r_wr && data_data_ok &&
                          ((r_state == REQ && data_addr_ok) || r_state == WAIT);

    // Request capture in IDLE and read-data buffer
    always_ff @(posedge clk) begin
        if (rst) begin
            r_wr        <= 1'b0;
            r_size      <= 2'd0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_rdata_buf <= 32'd0;
        end else begin
            if (r_state == IDLE && data_sram_en) begin
                r_wr    <= w_wr;
                r_size  <= w_size;
                r_addr  <= {data_sram_addr[ADDR_WIDTH-1:2], w_off};
                r_wdata <= data_sram_wdata;
            end
            if (w_rd_capture) r_rdata_buf <= data_rdata;
        end
    end

    assign data_wr         = r_wr;
    assign data_size       = r_size;
    assign data_addr       = r_addr;
    assign data_wdata      = r_wdata;
    // buffer keeps the last load through later stores and idle cycles
    assign data_sram_rdata = r_rdata_buf;

`ifdef DATA_SRAM_BRIDGE_STALL_CNT_EN
    logic [CNT_WIDTH-1:0] r_stall_cnt;

    // Count stalled cycles, wrapping naturally at the counter width
    always_ff @(posedge clk) begin
        if (rst)           r_stall_cnt <= '0;
        else if (stallreq) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
    end

    assign stall_cnt = r_stall_cnt;
`else
    // counter width is only meaningful when the counter is built
    if (CNT_WIDTH > 0) begin : g_no_stall_cnt
    end
`endif

endmodule
